sd_cmd_engine: RTL and testbench
================================

SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 Parameters SHALL be: NCR_MAX, default 64, number of cycles to wait for the response start bit; NCC_GAP, default 8, number of idle cycles between commands; LONG_LEN, default 136, long-response length in bits (at least 48).
REQ-002 Ports SHALL be:
- sd_clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- cmd_start  in  1  one-cycle request to send a command; accepted only while cmd_ready=1.
- cmd_content  in  40  {start, dir, index[5:0], arg[31:0]}; bit 39 is sent first.
- resp_type  in  2  00 none, 01 short with CRC/index check, 10 long, 11 short without CRC/index check (R3); sampled with cmd_start.
- cmd_abort  in  1  returns the block to IDLE from any state.
- cmd_in  in  1  CMD line from the card.
- cmd_out  out  1  CMD line to the card; idle level 1.
- cmd_oe  out  1  high while driving cmd_out.
- cmd_ready  out  1  high only in IDLE.
- cmd_sent_strb  out  1  one cycle after the end bit is driven.
- resp_valid_strb  out  1  one cycle; response and error flags are valid.
- resp_data  out  LONG_LEN  received response, right-aligned; short responses use [47:0] with the upper bits zero.
- crc_err, idx_err, end_err, timeout_err  out  1 each  error flags; held until the next accepted cmd_start.

Function
REQ-003 The FSM states SHALL be IDLE, SEND, WAIT_RESP, RECV, CHECK and GAP.
REQ-004 In IDLE, cmd_start=1 SHALL latch cmd_content and resp_type, clear all error flags and move to SEND; cmd_start in any other state SHALL be ignored.
REQ-005 The block SHALL compute CRC7 (G(x)=x^7+x^3+1, register initialised to 0) over the 40 content bits and form the packet {cmd_content, crc7[6:0], 1'b1}.
REQ-006 SEND timing:
- If cmd_start is accepted in cycle T, packet bit 47 SHALL appear on cmd_out in cycle T+1 and bit 0 in T+48, MSB first.
- cmd_oe SHALL be 1 exactly during T+1..T+48.
- cmd_sent_strb SHALL pulse in T+49.
REQ-007 After SEND, resp_type=00 SHALL go to GAP; any other resp_type SHALL go to WAIT_RESP.
REQ-008 WAIT_RESP SHALL count the cycles since entry. cmd_in=0 SHALL be taken as the start bit, stored as the MSB, and move the FSM to RECV. If the count reaches NCR_MAX with no start bit, the block SHALL set timeout_err, pulse resp_valid_strb and go to GAP.
REQ-009 RECV SHALL shift cmd_in in MSB first until 48 bits (types 01 and 11) or LONG_LEN bits (type 10) have been stored, start bit included, then go to CHECK. cmd_in SHALL be ignored while cmd_oe=1.
REQ-010 CHECK SHALL last one cycle, set the error flags below, pulse resp_valid_strb, update resp_data, then go to GAP.
- Short (type 01): crc_err if CRC7 over resp[47:8] differs from resp[7:1]; idx_err if resp[45:40] differs from the sent index.
- Long (type 10): crc_err if CRC7 over resp[127:8] differs from resp[7:1]; no index check.
- Type 11: no CRC or index check.
- All types: end_err if resp[0] is 0.
REQ-011 GAP SHALL hold cmd_out=1 and cmd_oe=0 for NCC_GAP cycles, then return to IDLE.
REQ-012 cmd_abort SHALL take priority over every transition: the next state is IDLE, cmd_oe=0, cmd_out=1, no strobe is issued, and resp_data and the error flags are unchanged.
REQ-013 Counters SHALL be wide enough for max(LONG_LEN, NCR_MAX, NCC_GAP) and SHALL not wrap.

Reset
REQ-014 reset_n=0 at a rising edge SHALL force the state to IDLE from any state, including mid-SEND or mid-RECV.
REQ-015 The values held during reset SHALL be: cmd_out=1, cmd_oe=0, cmd_ready=1, all strobes 0, resp_data all zeros, all error flags 0.
REQ-016 The initial register values SHALL equal the reset values.

Verification
REQ-017 CMD0: cmd_content=40'h40_0000_0000, type 00 -> cmd_out serialises 48'h40_0000_0000_95 over T+1..T+48; cmd_sent_strb at T+49; cmd_ready at T+49+NCC_GAP.
REQ-018 CMD8: content 40'h48_0000_01AA, type 01, card returns 48'h08_0000_01AA_13 -> serialised command 48'h48_0000_01AA_87; resp_data[47:0]=48'h08_0000_01AA_13; all error flags 0.
REQ-019 The same CMD8 response with bit 1 flipped -> crc_err=1; resp_data updated; idx_err=0.
REQ-020 Type 10 with a 136-bit response having a valid CRC and end bit -> resp_valid_strb exactly 136 cycles after the start bit; no error flags set.
REQ-021 Type 01 with cmd_in held at 1 -> timeout_err=1 and resp_valid_strb exactly NCR_MAX (64) cycles after WAIT_RESP entry.
REQ-022 reset_n=0 at bit 20 of SEND, and separately cmd_abort during RECV -> IDLE next cycle, cmd_oe=0, cmd_out=1, no strobe; a following cmd_start is accepted normally.

Source files
------------

// File: rtl/sd_cmd_engine.sv
// SD-card CMD line engine: serialises a 48-bit command with CRC7, then
// optionally collects and checks a short (48-bit) or long response.
module sd_cmd_engine #(
    parameter int NCR_MAX  = 64,
    parameter int NCC_GAP  = 8,
    parameter int LONG_LEN = 136
) (
    input  logic                sd_clk,
    input  logic                reset_n,
    input  logic                cmd_start,
    input  logic [39:0]         cmd_content,
    input  logic [1:0]          resp_type,
    input  logic                cmd_abort,
    input  logic                cmd_in,
    output logic                cmd_out,
    output logic                cmd_oe,
    output logic                cmd_ready,
    output logic                cmd_sent_strb,
    output logic                resp_valid_strb,
    output logic [LONG_LEN-1:0] resp_data,
    output logic                crc_err,
    output logic                idx_err,
    output logic                end_err,
    output logic                timeout_err
);

    localparam int CNT_A   = (LONG_LEN > NCR_MAX) ? LONG_LEN : NCR_MAX;
    localparam int CNT_B   = (CNT_A > NCC_GAP) ? CNT_A : NCC_GAP;
    localparam int CNT_MAX = (CNT_B > 48) ? CNT_B : 48;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SEND_LAST  = CW'(47);
    localparam logic [CW-1:0] SHORT_LAST = CW'(47);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_LEN - 1);
    localparam logic [CW-1:0] NCR_LAST   = CW'((NCR_MAX > 0) ? NCR_MAX - 1 : 0);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((NCC_GAP > 0) ? NCC_GAP - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEND  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_RECV  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [1:0] RT_NONE  = 2'b00;
    localparam logic [1:0] RT_SHORT = 2'b01;
    localparam logic [1:0] RT_LONG  = 2'b10;

    function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    logic [2:0]          state_q = S_IDLE;
    logic [2:0]          state_d;
    logic [CW-1:0]       cnt_q = '0;
    logic [CW-1:0]       cnt_d;
    logic [46:0]         tx_q = '0;
    logic [46:0]         tx_d;
    logic [LONG_LEN-2:0] rx_q = '0;
    logic [LONG_LEN-2:0] rx_d;
    logic [5:0]          idx_q = '0;
    logic [5:0]          idx_d;
    logic [1:0]          type_q = RT_NONE;
    logic [1:0]          type_d;
    logic                cmd_out_q = 1'b1;
    logic                cmd_out_d;
    logic                cmd_oe_q = 1'b0;
    logic                cmd_oe_d;
    logic                sent_strb_q = 1'b0;
    logic                sent_strb_d;
    logic                valid_strb_q = 1'b0;
    logic                valid_strb_d;
    logic [LONG_LEN-1:0] resp_q = '0;
    logic [LONG_LEN-1:0] resp_d;
    logic                crc_err_q = 1'b0;
    logic                crc_err_d;
    logic                idx_err_q = 1'b0;
    logic                idx_err_d;
    logic                end_err_q = 1'b0;
    logic                end_err_d;
    logic                timeout_err_q = 1'b0;
    logic                timeout_err_d;

    logic [LONG_LEN-1:0] rx_full;
    logic [127:0]        rx_wide;
    logic [6:0]          cmd_crc;
    logic [6:0]          crc_short;
    logic [6:0]          crc_long;
    logic [CW-1:0]       rx_last;

    // rx_full is the response as it will look once this cycle's bit is shifted in.
    assign rx_full = {rx_q, cmd_in};
    assign rx_last = (type_q == RT_LONG) ? LONG_LAST : SHORT_LAST;

    generate
        if (LONG_LEN >= 128) begin : g_wide_trunc
            assign rx_wide = rx_full[127:0];
        end else begin : g_wide_pad
            assign rx_wide = {{(128 - LONG_LEN){1'b0}}, rx_full};
        end
    endgenerate

    always_comb begin
        cmd_crc   = '0;
        crc_short = '0;
        crc_long  = '0;
        for (int i = 39; i >= 0; i--) begin
            cmd_crc = crc7_next(cmd_crc, cmd_content[i]);
        end
        for (int i = 47; i >= 8; i--) begin
            crc_short = crc7_next(crc_short, rx_wide[i]);
        end
        for (int i = 127; i >= 8; i--) begin
            crc_long = crc7_next(crc_long, rx_wide[i]);
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tx_d          = tx_q;
        rx_d          = rx_q;
        idx_d         = idx_q;
        type_d        = type_q;
        cmd_out_d     = 1'b1;
        cmd_oe_d      = 1'b0;
        sent_strb_d   = 1'b0;
        valid_strb_d  = 1'b0;
        resp_d        = resp_q;
        crc_err_d     = crc_err_q;
        idx_err_d     = idx_err_q;
        end_err_d     = end_err_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    idx_d         = cmd_content[37:32];
                    type_d        = resp_type;
                    tx_d          = {cmd_content[38:0], cmd_crc, 1'b1};
                    cmd_out_d     = cmd_content[39];
                    cmd_oe_d      = 1'b1;
                    cnt_d         = SEND_LAST;
                    crc_err_d     = 1'b0;
                    idx_err_d     = 1'b0;
                    end_err_d     = 1'b0;
                    timeout_err_d = 1'b0;
                    state_d       = S_SEND;
                end
            end
            S_SEND: begin
                if (cnt_q == '0) begin
                    sent_strb_d = 1'b1;
                    if (type_q == RT_NONE) begin
                        cnt_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end else begin
                    cmd_out_d = tx_q[46];
                    cmd_oe_d  = 1'b1;
                    tx_d      = {tx_q[45:0], 1'b1};
                    cnt_d     = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (!cmd_in) begin
                    // The start bit (0) enters as bit 0 and shifts up to the MSB.
                    rx_d    = '0;
                    cnt_d   = CW'(1);
                    state_d = S_RECV;
                end else if (cnt_q == NCR_LAST) begin
                    timeout_err_d = 1'b1;
                    valid_strb_d  = 1'b1;
                    cnt_d         = GAP_LOAD;
                    state_d       = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RECV: begin
                rx_d = rx_full[LONG_LEN-2:0];
                if (cnt_q == rx_last) begin
                    // Results are registered here so they are visible during CHECK.
                    resp_d       = rx_full;
                    valid_strb_d = 1'b1;
                    crc_err_d    = ((type_q == RT_SHORT) && (crc_short != rx_wide[7:1])) ||
                                   ((type_q == RT_LONG)  && (crc_long  != rx_wide[7:1]));
                    idx_err_d    = (type_q == RT_SHORT) && (rx_wide[45:40] != idx_q);
                    end_err_d    = ~rx_wide[0];
                    state_d      = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                cnt_d   = GAP_LOAD;
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a simultaneous cmd_start.
        if (cmd_abort) begin
            state_d       = S_IDLE;
            idx_d         = idx_q;
            type_d        = type_q;
            cmd_out_d     = 1'b1;
            cmd_oe_d      = 1'b0;
            sent_strb_d   = 1'b0;
            valid_strb_d  = 1'b0;
            resp_d        = resp_q;
            crc_err_d     = crc_err_q;
            idx_err_d     = idx_err_q;
            end_err_d     = end_err_q;
            timeout_err_d = timeout_err_q;
        end
    end

    always_ff @(posedge sd_clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            idx_q         <= '0;
            type_q        <= RT_NONE;
            cmd_out_q     <= 1'b1;
            cmd_oe_q      <= 1'b0;
            sent_strb_q   <= 1'b0;
            valid_strb_q  <= 1'b0;
            resp_q        <= '0;
            crc_err_q     <= 1'b0;
            idx_err_q     <= 1'b0;
            end_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            idx_q         <= idx_d;
            type_q        <= type_d;
            cmd_out_q     <= cmd_out_d;
            cmd_oe_q      <= cmd_oe_d;
            sent_strb_q   <= sent_strb_d;
            valid_strb_q  <= valid_strb_d;
            resp_q        <= resp_d;
            crc_err_q     <= crc_err_d;
            idx_err_q     <= idx_err_d;
            end_err_q     <= end_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign cmd_out         = cmd_out_q;
    assign cmd_oe          = cmd_oe_q;
    assign cmd_ready       = (state_q == S_IDLE);
    assign cmd_sent_strb   = sent_strb_q;
    assign resp_valid_strb = valid_strb_q;
    assign resp_data       = resp_q;
    assign crc_err         = crc_err_q;
    assign idx_err         = idx_err_q;
    assign end_err         = end_err_q;
    assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: command serialisation, response checks,
// timeout, abort and mid-command reset.
module tb_sd_cmd_engine;

    localparam int LONG_LEN = 136;
    localparam int NCR_MAX  = 64;
    localparam int NCC_GAP  = 8;

    logic                sd_clk = 1'b0;
    logic                reset_n;
    logic                cmd_start;
    logic [39:0]         cmd_content;
    logic [1:0]          resp_type;
    logic                cmd_abort;
    logic                cmd_in;
    logic                cmd_out;
    logic                cmd_oe;
    logic                cmd_ready;
    logic                cmd_sent_strb;
    logic                resp_valid_strb;
    logic [LONG_LEN-1:0] resp_data;
    logic                crc_err;
    logic                idx_err;
    logic                end_err;
    logic                timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 sd_clk = ~sd_clk;

    sd_cmd_engine #(
        .NCR_MAX (NCR_MAX),
        .NCC_GAP (NCC_GAP),
        .LONG_LEN(LONG_LEN)
    ) dut (
        .sd_clk         (sd_clk),
        .reset_n        (reset_n),
        .cmd_start      (cmd_start),
        .cmd_content    (cmd_content),
        .resp_type      (resp_type),
        .cmd_abort      (cmd_abort),
        .cmd_in         (cmd_in),
        .cmd_out        (cmd_out),
        .cmd_oe         (cmd_oe),
        .cmd_ready      (cmd_ready),
        .cmd_sent_strb  (cmd_sent_strb),
        .resp_valid_strb(resp_valid_strb),
        .resp_data      (resp_data),
        .crc_err        (crc_err),
        .idx_err        (idx_err),
        .end_err        (end_err),
        .timeout_err    (timeout_err)
    );

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge sd_clk);
    endtask

    function automatic logic [6:0] crc7_ref(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 119; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    task automatic send_cmd(input logic [39:0] content, input logic [1:0] rt, output logic [47:0] pkt);
        logic oe_all;
        logic strb_early;
        oe_all      = 1'b1;
        strb_early  = 1'b0;
        cmd_content = content;
        resp_type   = rt;
        cmd_start   = 1'b1;
        step();
        cmd_start = 1'b0;
        for (int k = 47; k >= 0; k--) begin
            pkt[k]     = cmd_out;
            oe_all     = oe_all & cmd_oe;
            strb_early = strb_early | cmd_sent_strb;
            step();
        end
        chk("oe_during_send", 136'(oe_all), 136'(1));
        chk("sent_strb_early", 136'(strb_early), 136'(0));
        chk("sent_strb", 136'(cmd_sent_strb), 136'(1));
        chk("oe_after_send", 136'(cmd_oe), 136'(0));
    endtask

    task automatic drive_resp(input logic [135:0] r, input int len, input int dly);
        cmd_in = 1'b1;
        repeat (dly) step();
        for (int i = len - 1; i >= 0; i--) begin
            cmd_in = r[i];
            if (i == 0) chk("valid_strb_early", 136'(resp_valid_strb), 136'(0));
            step();
        end
        cmd_in = 1'b1;
        chk("valid_strb", 136'(resp_valid_strb), 136'(1));
    endtask

    task automatic chk_flags(input logic c, input logic i, input logic e, input logic t);
        chk("crc_err", 136'(crc_err), 136'(c));
        chk("idx_err", 136'(idx_err), 136'(i));
        chk("end_err", 136'(end_err), 136'(e));
        chk("timeout_err", 136'(timeout_err), 136'(t));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 40) begin
            step();
            n++;
        end
        chk("ready_wait", 136'(cmd_ready), 136'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0]  pkt;
        logic [119:0] payload;
        logic [135:0] long_resp;
        logic         seen;

        payload   = 120'hDEADBEEF_0123_4567_89AB_CDEF_123456;
        long_resp = {8'h3F, payload, crc7_ref(payload), 1'b1};

        reset_n     = 1'b0;
        cmd_start   = 1'b0;
        cmd_content = '0;
        resp_type   = 2'b00;
        cmd_abort   = 1'b0;
        cmd_in      = 1'b1;
        repeat (3) step();
        chk("rst_cmd_out", 136'(cmd_out), 136'(1));
        chk("rst_cmd_oe", 136'(cmd_oe), 136'(0));
        chk("rst_ready", 136'(cmd_ready), 136'(1));
        chk("rst_sent_strb", 136'(cmd_sent_strb), 136'(0));
        chk("rst_valid_strb", 136'(resp_valid_strb), 136'(0));
        chk("rst_resp_data", resp_data, 136'(0));
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0);
        $display("txn reset checked");
        reset_n = 1'b1;
        step();

        // CMD0, no response; ready returns NCC_GAP cycles after the sent strobe.
        send_cmd(40'h40_0000_0000, 2'b00, pkt);
        chk("cmd0_pkt", 136'(pkt), 136'(48'h40_0000_0000_95));
        repeat (NCC_GAP - 1) step();
        chk("cmd0_ready_early", 136'(cmd_ready), 136'(0));
        step();
        chk("cmd0_ready", 136'(cmd_ready), 136'(1));
        $display("txn CMD0 pkt=%012h", pkt);

        send_cmd(40'h48_0000_01AA, 2'b01, pkt);
        chk("cmd8_pkt", 136'(pkt), 136'(48'h48_0000_01AA_87));
        drive_resp(136'(48'h08_0000_01AA_13), 48, 3);
        chk("cmd8_resp", resp_data, 136'(48'h08_0000_01AA_13));
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0);
        $display("txn CMD8 good resp=%012h", resp_data[47:0]);
        wait_ready();

        send_cmd(40'h48_0000_01AA, 2'b01, pkt);
        drive_resp(136'(48'h08_0000_01AA_11), 48, 2);
        chk("cmd8_bad_resp", resp_data, 136'(48'h08_0000_01AA_11));
        chk_flags(1'b1, 1'b0, 1'b0, 1'b0);
        $display("txn CMD8 crc-flip resp=%012h", resp_data[47:0]);
        wait_ready();

        // R3: CRC field and index are not checked, only the end bit.
        send_cmd(40'h69_40FF_8000, 2'b11, pkt);
        drive_resp(136'(48'h3F_00FF_8000_FE), 48, 1);
        chk("r3_resp", resp_data, 136'(48'h3F_00FF_8000_FE));
        chk_flags(1'b0, 1'b0, 1'b1, 1'b0);
        $display("txn R3 resp=%012h", resp_data[47:0]);
        wait_ready();

        send_cmd(40'h42_0000_0000, 2'b10, pkt);
        chk("long_flags_cleared", 136'(end_err), 136'(0));
        drive_resp(long_resp, 136, 4);
        chk("long_resp", resp_data, long_resp);
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0);
        $display("txn long resp=%034h", resp_data);
        wait_ready();

        // Timeout: strobe exactly NCR_MAX cycles after WAIT_RESP entry.
        send_cmd(40'h48_0000_01AA, 2'b01, pkt);
        repeat (NCR_MAX - 1) step();
        chk("timeout_early", 136'(resp_valid_strb), 136'(0));
        step();
        chk("timeout_strb", 136'(resp_valid_strb), 136'(1));
        chk_flags(1'b0, 1'b0, 1'b0, 1'b1);
        chk("timeout_data_kept", resp_data, long_resp);
        $display("txn timeout");
        wait_ready();

        // Abort in the middle of a response.
        send_cmd(40'h48_0000_01AA, 2'b01, pkt);
        chk("abort_to_cleared", 136'(timeout_err), 136'(0));
        repeat (2) step();
        pkt = 48'h08_0000_01AA_13;
        for (int i = 47; i >= 36; i--) begin
            cmd_in = pkt[i];
            step();
        end
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
        chk("abort_ready", 136'(cmd_ready), 136'(1));
        chk("abort_oe", 136'(cmd_oe), 136'(0));
        chk("abort_out", 136'(cmd_out), 136'(1));
        seen = resp_valid_strb | cmd_sent_strb;
        for (int i = 35; i >= 0; i--) begin
            cmd_in = pkt[i];
            step();
            seen = seen | resp_valid_strb | cmd_sent_strb;
        end
        cmd_in = 1'b1;
        repeat (6) begin
            step();
            seen = seen | resp_valid_strb;
        end
        chk("abort_no_strb", 136'(seen), 136'(0));
        chk("abort_data_kept", resp_data, long_resp);
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0);
        send_cmd(40'h48_0000_01AA, 2'b01, pkt);
        chk("post_abort_pkt", 136'(pkt), 136'(48'h48_0000_01AA_87));
        drive_resp(136'(48'h08_0000_01AA_13), 48, 2);
        chk("post_abort_resp", resp_data, 136'(48'h08_0000_01AA_13));
        $display("txn abort during RECV then CMD8");
        wait_ready();

        // Reset while the command is still being shifted out.
        cmd_content = 40'h48_0000_01AA;
        resp_type   = 2'b01;
        cmd_start   = 1'b1;
        step();
        cmd_start = 1'b0;
        repeat (19) step();
        chk("midsend_oe", 136'(cmd_oe), 136'(1));
        reset_n = 1'b0;
        step();
        chk("rst_send_ready", 136'(cmd_ready), 136'(1));
        chk("rst_send_oe", 136'(cmd_oe), 136'(0));
        chk("rst_send_out", 136'(cmd_out), 136'(1));
        chk("rst_send_strb", 136'(cmd_sent_strb), 136'(0));
        chk("rst_send_data", resp_data, 136'(0));
        reset_n = 1'b1;
        step();
        send_cmd(40'h40_0000_0000, 2'b00, pkt);
        chk("post_rst_pkt", 136'(pkt), 136'(48'h40_0000_0000_95));
        $display("txn reset mid-SEND then CMD0");
        wait_ready();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
